// File: rtl/psum_accum_wb.sv
// -----------------------------------------------------------------------------
// psum_accum_wb
//
// Read-modify-write accumulation stage that sits in front of the psum global
// buffer. Each accepted transaction carries X_dim signed partial sums. Lane i
// targets buffer address in_addr+i, with the address wrapping modulo
// 2^ADDR_BITWIDTH.
//   - in_first=1 : every lane overwrites its buffer word (one write per cycle).
//   - in_first=0 : every lane reads the stored word, adds the new value with
//                  saturation, and writes the result back. Each lane takes one
//                  read cycle followed by one write cycle.
//
// Ports
//   clk       in   clock; all state changes on the rising edge
//   reset     in   synchronous, active-high reset
//   in_valid  in   an input vector is present
//   in_ready  out  block is idle and can accept a vector
//   in_data   in   X_dim lanes; lane i = in_data[i*DATA_BITWIDTH +: DATA_BITWIDTH]
//   in_addr   in   buffer address of lane 0
//   in_first  in   1 = overwrite, 0 = accumulate
//   read_req  out  buffer read request
//   r_addr    out  buffer read address
//   r_data    in   buffer read data, valid in the cycle after read_req
//   write_en  out  buffer write enable
//   w_addr    out  buffer write address
//   w_data    out  buffer write data
//   vec_done  out  one-cycle pulse that accompanies the last lane's write
//   sat_flag  out  sticky flag: some accumulate saturated (cleared by reset only)
// -----------------------------------------------------------------------------
module psum_accum_wb #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10,
  parameter int X_dim         = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_BITWIDTH*X_dim-1:0]   in_data,
  input  logic [ADDR_BITWIDTH-1:0]         in_addr,
  input  logic                             in_first,
  output logic                             read_req,
  output logic [ADDR_BITWIDTH-1:0]         r_addr,
  input  logic [DATA_BITWIDTH-1:0]         r_data,
  output logic                             write_en,
  output logic [ADDR_BITWIDTH-1:0]         w_addr,
  output logic [DATA_BITWIDTH-1:0]         w_data,
  output logic                             vec_done,
  output logic                             sat_flag
);

  localparam int LANE_W = (X_dim > 1) ? $clog2(X_dim) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(X_dim - 1);
  localparam logic [DATA_BITWIDTH-1:0] SAT_MAX = {1'b0, {(DATA_BITWIDTH-1){1'b1}}};
  localparam logic [DATA_BITWIDTH-1:0] SAT_MIN = {1'b1, {(DATA_BITWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    ACC  = 2'd2,
    WR   = 2'd3
  } state_t;

  state_t                           state_q, state_d;
  logic [LANE_W-1:0]                lane_q, lane_d;
  logic [ADDR_BITWIDTH-1:0]         base_q, base_d;
  logic [DATA_BITWIDTH*X_dim-1:0]   data_q, data_d;
  logic                             sat_q, sat_d;

  // Latched vector unpacked into one word per lane.
  logic [DATA_BITWIDTH-1:0] lane_vec [X_dim];

  generate
    for (genvar gi = 0; gi < X_dim; gi++) begin : g_lane_unpack
      assign lane_vec[gi] = data_q[gi*DATA_BITWIDTH +: DATA_BITWIDTH];
    end
  endgenerate

  // Select the current lane from the latched vector. The compare-mux keeps the
  // selection within X_dim entries even when X_dim is not a power of two.
  logic [DATA_BITWIDTH-1:0] lane_data;

  always_comb begin
    lane_data = '0;
    for (int i = 0; i < X_dim; i++) begin
      if (lane_q == LANE_W'(i)) begin
        lane_data = lane_vec[i];
      end
    end
  end

  // The buffer address of the current lane. The addition truncates to
  // ADDR_BITWIDTH, so the address wraps past the top of the buffer.
  logic [ADDR_BITWIDTH-1:0] lane_addr;
  logic                     last_lane;

  assign lane_addr = base_q + ADDR_BITWIDTH'(lane_q);
  assign last_lane = (lane_q == LAST_LANE);

  // Saturating add, computed one bit wider than the data. The result has
  // overflowed when the top two bits of the wide sum differ. In that case the
  // top bit gives the true sign of the sum, and so selects which rail to clamp to.
  logic [DATA_BITWIDTH:0]   sum_ext;
  logic                     sum_ovf;
  logic [DATA_BITWIDTH-1:0] sum_sat;

  assign sum_ext = {r_data[DATA_BITWIDTH-1], r_data}
                 + {lane_data[DATA_BITWIDTH-1], lane_data};
  assign sum_ovf = sum_ext[DATA_BITWIDTH] ^ sum_ext[DATA_BITWIDTH-1];
  assign sum_sat = !sum_ovf ? sum_ext[DATA_BITWIDTH-1:0]
                 : (sum_ext[DATA_BITWIDTH] ? SAT_MIN : SAT_MAX);

  // Next-state logic and output decode. All buffer-side outputs depend only on
  // the registered state. r_data reaches w_data only in ACC, and every address
  // or data output that is not in use is held at 0.
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    base_d   = base_q;
    data_d   = data_q;
    sat_d    = sat_q;
    in_ready = 1'b0;
    read_req = 1'b0;
    r_addr   = '0;
    write_en = 1'b0;
    w_addr   = '0;
    w_data   = '0;
    vec_done = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          base_d  = in_addr;
          lane_d  = '0;
          state_d = in_first ? WR : RD;
        end
      end

      RD: begin
        read_req = 1'b1;
        r_addr   = lane_addr;
        state_d  = ACC;
      end

      ACC: begin
        write_en = 1'b1;
        w_addr   = lane_addr;
        w_data   = sum_sat;
        if (sum_ovf) begin
          sat_d = 1'b1;
        end
        if (last_lane) begin
          vec_done = 1'b1;
          state_d  = IDLE;
        end else begin
          lane_d  = lane_q + LANE_W'(1);
          state_d = RD;
        end
      end

      WR: begin
        write_en = 1'b1;
        w_addr   = lane_addr;
        w_data   = lane_data;
        if (last_lane) begin
          vec_done = 1'b1;
          state_d  = IDLE;
        end else begin
          lane_d = lane_q + LANE_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sat_flag = sat_q;

  // Reset discards any vector that is in flight. Because every buffer output is
  // decoded from state, no write can follow the reset edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q  <= '0;
      base_q  <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      base_q  <= base_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_psum_accum_wb.sv
module tb_psum_accum_wb;

  localparam int DW   = 16;
  localparam int AW   = 10;
  localparam int XD   = 3;
  localparam int SMAX = 32767;
  localparam int SMIN = -32768;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DW*XD-1:0]  in_data;
  logic [AW-1:0]     in_addr;
  logic              in_first;
  logic              read_req;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_data;
  logic              write_en;
  logic [AW-1:0]     w_addr;
  logic [DW-1:0]     w_data;
  logic              vec_done;
  logic              sat_flag;

  always #5 clk = ~clk;

  psum_accum_wb #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .X_dim(XD)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_addr(in_addr), .in_first(in_first),
    .read_req(read_req), .r_addr(r_addr), .r_data(r_data),
    .write_en(write_en), .w_addr(w_addr), .w_data(w_data),
    .vec_done(vec_done), .sat_flag(sat_flag)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Cycle index: the number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: one read port with one cycle of latency, one write port, and
  // a preload port that the bench uses. r_data carries garbage when no read
  // result is due.
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] rd_data_q;
  logic          rd_pending;
  logic [DW-1:0] garbage;
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  logic          clr_en;

  always @(posedge clk) begin
    if (clr_en) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else begin
      if (pl_en) mem[pl_addr] <= pl_data;
      if (write_en) mem[w_addr] <= w_data;
    end
    rd_pending <= read_req;
    if (read_req) rd_data_q <= mem[r_addr];
  end

  assign r_data = rd_pending ? rd_data_q : garbage;

  // Monitor: records every write and read, and counts port conflicts.
  typedef struct {
    int addr;
    int data;
    int cyc;
    bit done;
  } wr_t;

  wr_t wq[$];
  int  rq[$];
  int  excl_viol = 0;

  always @(negedge clk) begin
    wr_t e;
    if (write_en) begin
      e.addr = int'(w_addr);
      e.data = int'($signed(w_data));
      e.cyc  = cyc;
      e.done = vec_done;
      wq.push_back(e);
    end
    if (read_req) rq.push_back(int'(r_addr));
    if (read_req && write_en) excl_viol++;
  end

  // Reference model: the buffer contents and the sticky saturation flag, kept
  // as plain integers.
  int ref_mem [0:1023];
  bit ref_sat;
  int exp_addr [XD];
  int exp_data [XD];
  int exp_cyc  [XD];

  // Expected write sequence for one vector. The vector is accepted on the edge
  // that ends cycle acc.
  function automatic void model_vec(input bit first, input int base, input int lanes[XD], input int acc);
    int a, s, v;
    for (int i = 0; i < XD; i++) begin
      a = (base + i) % 1024;
      if (first) begin
        v = lanes[i];
        exp_cyc[i] = acc + 1 + i;
      end else begin
        s = ref_mem[a] + lanes[i];
        if (s > SMAX) begin
          v = SMAX;
          ref_sat = 1'b1;
        end else if (s < SMIN) begin
          v = SMIN;
          ref_sat = 1'b1;
        end else begin
          v = s;
        end
        exp_cyc[i] = acc + 2 + 2 * i;
      end
      ref_mem[a] = v;
      exp_addr[i] = a;
      exp_data[i] = v;
    end
  endfunction

  task automatic preload(input int addr, input int val);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = addr[AW-1:0];
    pl_data = val[DW-1:0];
    ref_mem[addr] = val;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  // Present one vector, hold it for its acceptance edge, then scramble the
  // inputs. acc returns the cycle whose closing edge accepted the vector.
  task automatic send_vec(input bit first, input int base, input int lanes[XD], output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_ready: in_ready=%0b required 1", in_ready);
    end
    wq.delete();
    rq.delete();
    in_first = first;
    in_addr  = base[AW-1:0];
    for (int i = 0; i < XD; i++) in_data[i*DW +: DW] = lanes[i][DW-1:0];
    in_valid = 1'b1;
    acc = cyc;
    model_vec(first, base, lanes, acc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    in_addr  = AW'($urandom);
    in_first = 1'($urandom);
  endtask

  // Wait for vec_done, then wait one more cycle so that the final write has
  // landed and sat_flag has updated.
  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vec_done && n < 40);
    if (!vec_done) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_done: vec_done=%0b required 1 within 40 cycles", vec_done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int l[XD];
    int acc;
    // Reset is still asserted here, and two reset edges have already passed.
    n_cmp++;
    if (in_ready !== 1'b1 || read_req !== 1'b0 || write_en !== 1'b0 || vec_done !== 1'b0 ||
        sat_flag !== 1'b0 || r_addr !== '0 || w_addr !== '0 || w_data !== '0) begin
      n_err++;
      $display("FAIL reset_por: rdy=%0b rreq=%0b wen=%0b done=%0b sat=%0b ra=%0d wa=%0d wd=%0d required 1 0 0 0 0 0 0 0",
               in_ready, read_req, write_en, vec_done, sat_flag, r_addr, w_addr, w_data);
    end
    reset = 1'b0;
    for (int i = 0; i < XD; i++) preload(100 + i, 0);
    l = '{1, 2, 3};
    send_vec(1'b0, 100, l, acc);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    // This is cycle acc+3. Lane 0 was written in acc+2, and lane 1 is reading now.
    reset = 1'b1;
    n_cmp++;
    if (wq.size() !== 1) begin
      n_err++;
      $display("FAIL reset_pre_writes: writes=%0d required 1", wq.size());
    end
    @(negedge clk);
    wq.delete();
    n_cmp++;
    if (in_ready !== 1'b1 || read_req !== 1'b0 || write_en !== 1'b0 || vec_done !== 1'b0 ||
        sat_flag !== 1'b0 || r_addr !== '0 || w_addr !== '0 || w_data !== '0) begin
      n_err++;
      $display("FAIL reset_mid: rdy=%0b rreq=%0b wen=%0b done=%0b sat=%0b ra=%0d wa=%0d wd=%0d required 1 0 0 0 0 0 0 0",
               in_ready, read_req, write_en, vec_done, sat_flag, r_addr, w_addr, w_data);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (wq.size() !== 0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_no_write: writes=%0d in_ready=%0b required 0 1", wq.size(), in_ready);
    end
    n_cmp++;
    if ($signed(mem[100]) !== 16'sd1 || mem[101] !== 16'd0 || mem[102] !== 16'd0) begin
      n_err++;
      $display("FAIL reset_mem: mem[100..102]=%0d,%0d,%0d required 1,0,0",
               $signed(mem[100]), $signed(mem[101]), $signed(mem[102]));
    end
    // Only lane 0 completed, so the model's lanes 1 and 2 revert to the preload.
    ref_mem[101] = 0;
    ref_mem[102] = 0;
  endtask

  task automatic test_overwrite();
    int l[XD];
    int acc;
    garbage = 16'd10101;
    l = '{5, -7, 100};
    send_vec(1'b1, 10, l, acc);
    wait_done();
    n_cmp++;
    if (wq.size() !== XD || rq.size() !== 0) begin
      n_err++;
      $display("FAIL ovw_count: writes=%0d reads=%0d required %0d 0", wq.size(), rq.size(), XD);
    end
    for (int i = 0; i < XD && i < wq.size(); i++) begin
      n_cmp++;
      if (wq[i].addr !== exp_addr[i] || wq[i].data !== exp_data[i] || wq[i].cyc !== exp_cyc[i] || wq[i].done !== (i == XD - 1)) begin
        n_err++;
        $display("FAIL ovw_lane%0d: addr=%0d data=%0d cyc=%0d done=%0b required %0d %0d %0d %0b",
                 i, wq[i].addr, wq[i].data, wq[i].cyc, wq[i].done, exp_addr[i], exp_data[i], exp_cyc[i], (i == XD - 1));
      end
    end
  endtask

  task automatic test_accumulate();
    int l[XD];
    int acc;
    preload(10, 5);
    preload(11, -7);
    preload(12, 100);
    garbage = 16'd10101;
    l = '{1, 2, -200};
    send_vec(1'b0, 10, l, acc);
    wait_done();
    n_cmp++;
    if (wq.size() !== XD || rq.size() !== XD) begin
      n_err++;
      $display("FAIL acc_count: writes=%0d reads=%0d required %0d %0d", wq.size(), rq.size(), XD, XD);
    end
    for (int i = 0; i < XD && i < rq.size(); i++) begin
      n_cmp++;
      if (rq[i] !== 10 + i) begin
        n_err++;
        $display("FAIL acc_raddr%0d: r_addr=%0d required %0d", i, rq[i], 10 + i);
      end
    end
    for (int i = 0; i < XD && i < wq.size(); i++) begin
      n_cmp++;
      if (wq[i].addr !== exp_addr[i] || wq[i].data !== exp_data[i] || wq[i].cyc !== exp_cyc[i] || wq[i].done !== (i == XD - 1)) begin
        n_err++;
        $display("FAIL acc_lane%0d: addr=%0d data=%0d cyc=%0d done=%0b required %0d %0d %0d %0b",
                 i, wq[i].addr, wq[i].data, wq[i].cyc, wq[i].done, exp_addr[i], exp_data[i], exp_cyc[i], (i == XD - 1));
      end
    end
  endtask

  task automatic test_saturation();
    int l[XD];
    int acc;
    n_cmp++;
    if (sat_flag !== 1'b0) begin
      n_err++;
      $display("FAIL sat_before: sat_flag=%0b required 0", sat_flag);
    end
    preload(0, 32760);
    preload(1, -32760);
    preload(2, 0);
    garbage = 16'h7fff;
    l = '{100, -100, 7};
    send_vec(1'b0, 0, l, acc);
    wait_done();
    for (int i = 0; i < XD; i++) begin
      n_cmp++;
      if (i >= wq.size()) begin
        n_err++;
        $display("FAIL sat_lane%0d: missing write, writes=%0d required %0d", i, wq.size(), XD);
      end else if (wq[i].addr !== exp_addr[i] || wq[i].data !== exp_data[i] || wq[i].cyc !== exp_cyc[i]) begin
        n_err++;
        $display("FAIL sat_lane%0d: addr=%0d data=%0d cyc=%0d required %0d %0d %0d",
                 i, wq[i].addr, wq[i].data, wq[i].cyc, exp_addr[i], exp_data[i], exp_cyc[i]);
      end
    end
    n_cmp++;
    if (sat_flag !== 1'b1) begin
      n_err++;
      $display("FAIL sat_set: sat_flag=%0b required 1", sat_flag);
    end
    for (int i = 0; i < XD; i++) preload(50 + i, 0);
    l = '{1, 2, 3};
    send_vec(1'b0, 50, l, acc);
    wait_done();
    n_cmp++;
    if (sat_flag !== 1'b1 || wq.size() !== XD || (wq.size() == XD && wq[2].data !== 3)) begin
      n_err++;
      $display("FAIL sat_sticky: sat_flag=%0b writes=%0d required 1 %0d", sat_flag, wq.size(), XD);
    end
  endtask

  task automatic test_wrap();
    int l[XD];
    int acc;
    l = '{1, 2, 3};
    send_vec(1'b1, 1023, l, acc);
    wait_done();
    for (int i = 0; i < XD; i++) begin
      n_cmp++;
      if (i >= wq.size()) begin
        n_err++;
        $display("FAIL wrap_lane%0d: missing write, writes=%0d required %0d", i, wq.size(), XD);
      end else if (wq[i].addr !== exp_addr[i] || wq[i].data !== exp_data[i] || wq[i].cyc !== exp_cyc[i]) begin
        n_err++;
        $display("FAIL wrap_lane%0d: addr=%0d data=%0d cyc=%0d required %0d %0d %0d",
                 i, wq[i].addr, wq[i].data, wq[i].cyc, exp_addr[i], exp_data[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int l[XD];
    int a1, a2, n;
    int e_addr[2*XD];
    int e_data[2*XD];
    int e_cyc[2*XD];
    for (int i = 0; i < XD; i++) preload(20 + i, 0);
    l = '{1, 1, 1};
    garbage = 16'($urandom);
    @(negedge clk);
    wq.delete();
    rq.delete();
    in_first = 1'b0;
    in_addr  = 10'd20;
    for (int i = 0; i < XD; i++) in_data[i*DW +: DW] = l[i][DW-1:0];
    in_valid = 1'b1;
    a1 = cyc;
    model_vec(1'b0, 20, l, a1);
    for (int i = 0; i < XD; i++) begin
      e_addr[i] = exp_addr[i];
      e_data[i] = exp_data[i];
      e_cyc[i]  = exp_cyc[i];
    end
    @(posedge clk);
    // in_valid stays high. The second, identical vector is accepted once the
    // block returns to IDLE.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 40);
    a2 = cyc;
    n_cmp++;
    if (a2 !== a1 + 2 * XD + 1) begin
      n_err++;
      $display("FAIL b2b_accept: second acceptance cycle=%0d required %0d", a2, a1 + 2 * XD + 1);
    end
    model_vec(1'b0, 20, l, a2);
    for (int i = 0; i < XD; i++) begin
      e_addr[XD + i] = exp_addr[i];
      e_data[XD + i] = exp_data[i];
      e_cyc[XD + i]  = exp_cyc[i];
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done();
    for (int i = 0; i < 2 * XD; i++) begin
      n_cmp++;
      if (i >= wq.size()) begin
        n_err++;
        $display("FAIL b2b_w%0d: missing write, writes=%0d required %0d", i, wq.size(), 2 * XD);
      end else if (wq[i].addr !== e_addr[i] || wq[i].data !== e_data[i] || wq[i].cyc !== e_cyc[i]) begin
        n_err++;
        $display("FAIL b2b_w%0d: addr=%0d data=%0d cyc=%0d required %0d %0d %0d",
                 i, wq[i].addr, wq[i].data, wq[i].cyc, e_addr[i], e_data[i], e_cyc[i]);
      end
    end
    n_cmp++;
    if (mem[20] !== 16'd2 || mem[21] !== 16'd2 || mem[22] !== 16'd2) begin
      n_err++;
      $display("FAIL b2b_mem: mem[20..22]=%0d,%0d,%0d required 2,2,2",
               $signed(mem[20]), $signed(mem[21]), $signed(mem[22]));
    end
  endtask

  task automatic test_random();
    int l[XD];
    int acc, base;
    bit first;
    for (int v = 0; v < 10; v++) begin
      first = 1'($urandom);
      base  = ($urandom_range(0, 3) == 0) ? 1023 - int'($urandom_range(0, 1)) : int'($urandom_range(0, 1023));
      for (int i = 0; i < XD; i++) l[i] = int'($signed(16'($urandom)));
      garbage = 16'($urandom);
      send_vec(first, base, l, acc);
      wait_done();
      n_cmp++;
      if (wq.size() !== XD || rq.size() !== (first ? 0 : XD)) begin
        n_err++;
        $display("FAIL rnd%0d_count: writes=%0d reads=%0d required %0d %0d", v, wq.size(), rq.size(), XD, first ? 0 : XD);
      end
      for (int i = 0; i < XD && i < wq.size(); i++) begin
        n_cmp++;
        if (wq[i].addr !== exp_addr[i] || wq[i].data !== exp_data[i] || wq[i].cyc !== exp_cyc[i] || wq[i].done !== (i == XD - 1)) begin
          n_err++;
          $display("FAIL rnd%0d_lane%0d: addr=%0d data=%0d cyc=%0d done=%0b required %0d %0d %0d %0b",
                   v, i, wq[i].addr, wq[i].data, wq[i].cyc, wq[i].done, exp_addr[i], exp_data[i], exp_cyc[i], (i == XD - 1));
        end
      end
      n_cmp++;
      if (sat_flag !== ref_sat) begin
        n_err++;
        $display("FAIL rnd%0d_sat: sat_flag=%0b required %0b", v, sat_flag, ref_sat);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_addr  = '0;
    in_first = 1'b0;
    pl_en    = 1'b0;
    pl_addr  = '0;
    pl_data  = '0;
    clr_en   = 1'b1;
    garbage  = 16'd10101;
    ref_sat  = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr_en = 1'b0;

    test_reset();
    test_overwrite();
    test_accumulate();
    test_saturation();
    test_wrap();
    test_back_to_back();
    test_random();

    n_cmp++;
    if (excl_viol !== 0) begin
      n_err++;
      $display("FAIL port_exclusive: cycles with read_req and write_en both high=%0d required 0", excl_viol);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
